// File: rtl/rx_frame_checker.sv
// -----------------------------------------------------------------------------
// rx_frame_checker
//
// Store-and-forward GMII receive front end. Strips preamble/SFD and writes each
// frame body into a circular byte RAM while checking FCS, length and rx_er.
// Good frames are committed to a small descriptor FIFO and replayed later as
// one contiguous rx_enable burst. Bad frames are rolled back: the write pointer
// returns to the frame start, so their bytes are overwritten by the next frame
// and never reach downstream.
//
// Build option:
//   RX_FCS_STRIP_EN  defined   : the 4 FCS bytes are not replayed (out_len = len-4)
//                    undefined : the FCS bytes are replayed last (out_len = len)
//
// Ports:
//   rx_clk      in   1   GMII receive clock, the only clock
//   reset       in   1   asynchronous, active-high
//   gmii_rxd    in   8   GMII receive data
//   gmii_rx_dv  in   1   GMII data valid
//   gmii_rx_er  in   1   GMII receive error
//   rx_data     out  8   replayed frame byte, 0 while rx_enable is low
//   rx_enable   out  1   high for every byte of one replayed frame, no holes
//   frame_good  out  1   one-cycle pulse: frame committed to the descriptor FIFO
//   frame_bad   out  1   one-cycle pulse: frame discarded (any cause)
//   drop_count  out 16   discarded-frame count, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module rx_frame_checker #(
    parameter int ADDR_W    = 11,
    parameter int DESC_W    = 2,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518,
    parameter int GAP_CYC   = 2
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_enable,
    output logic        frame_good,
    output logic        frame_bad,
    output logic [15:0] drop_count
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int DESC_DEPTH = 1 << DESC_W;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PTR_W      = ADDR_W + 1;
    // Length counter must hold MAX_FRAME+1 (its saturation value).
    localparam int LEN_W      = $clog2(MAX_FRAME + 2);
    localparam int GAP_W      = $clog2(GAP_CYC + 2);

`ifdef RX_FCS_STRIP_EN
    localparam int FCS_SKIP = 4;
`else
    localparam int FCS_SKIP = 0;
`endif

    localparam logic [7:0]       PRE_BYTE    = 8'h55;
    localparam logic [7:0]       SFD_BYTE    = 8'hD5;
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(MAX_FRAME);
    localparam logic [LEN_W-1:0] LEN_SAT     = LEN_W'(MAX_FRAME + 1);
    localparam logic [LEN_W-1:0] FCS_LEN     = LEN_W'(FCS_SKIP);
    localparam logic [PTR_W-1:0] RD_LAST_INC = PTR_W'(1 + FCS_SKIP);
    localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'(GAP_CYC);
    localparam logic [DESC_W:0]  DESC_FULL   = (DESC_W + 1)'(DESC_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_PRE, W_BODY, W_CHECK} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_RUN, R_GAP}           rd_state_t;

    typedef struct packed {
        logic [PTR_W-1:0] start;
        logic [LEN_W-1:0] len;
    } desc_t;

    // -------------------------------------------------------------------------
    // Byte-wise CRC-32, reflected form (poly 0x04C11DB7 bit-reversed).
    // -------------------------------------------------------------------------
    function automatic logic [31:0] crc32_step(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        // NOTE: inside functions and combinational code each statement must see
        // the previous one's result, so blocking '=' is required here; clocked
        // state elsewhere uses '<=' so all registers update together.
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    wr_state_t        wr_state;
    rd_state_t        rd_state;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] frame_start;
    logic [LEN_W-1:0] len;
    logic [31:0]      crc;
    logic             rx_err_seen;
    logic             ovf_seen;

    logic [7:0]       mem [DEPTH];
    logic [7:0]       ram_q;

    desc_t            desc_mem [DESC_DEPTH];
    logic [DESC_W-1:0] desc_wr_idx;
    logic [DESC_W-1:0] desc_rd_idx;
    logic [DESC_W:0]  desc_count;
    desc_t            desc_head;

    logic [LEN_W-1:0] rd_remain;
    logic [GAP_W-1:0] gap_cnt;
    logic             fetch_valid;

    // -------------------------------------------------------------------------
    // Write-side combinational helpers
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_inc;
    logic             buf_full_next;
    logic             len_below_max;
    logic             body_byte;
    logic             ram_we;
    logic             len_in_range;
    logic             crc_ok;
    logic             desc_full;
    logic             frame_ok;
    logic             desc_push;
    logic             desc_pop;
    logic             rd_fetch;
    logic [LEN_W-1:0] out_len;

    assign wr_ptr_inc    = wr_ptr + 1'b1;
    // Writing one more byte would make the addresses meet with the wrap bits
    // differing, i.e. the ring would be completely full.
    assign buf_full_next = (wr_ptr_inc == {~rd_ptr[ADDR_W], rd_ptr[ADDR_W-1:0]});
    assign len_below_max = (len < MAX_LEN);
    assign body_byte     = (wr_state == W_BODY) && gmii_rx_dv;
    assign ram_we        = body_byte && len_below_max && !ovf_seen && !buf_full_next;

    assign len_in_range  = (len >= MIN_LEN) && (len <= MAX_LEN);
    assign crc_ok        = (crc == CRC_RESIDUE);
    assign desc_full     = (desc_count == DESC_FULL);
    assign frame_ok      = crc_ok && len_in_range && !rx_err_seen && !ovf_seen && !desc_full;
    assign desc_push     = (wr_state == W_CHECK) && frame_ok;
    assign out_len       = len - FCS_LEN;

    assign desc_head     = desc_mem[desc_rd_idx];
    assign desc_pop      = (rd_state == R_IDLE) && (desc_count != '0);
    assign rd_fetch      = (rd_state == R_RUN);

    // -------------------------------------------------------------------------
    // Write FSM: preamble hunt, body capture, frame verdict
    // -------------------------------------------------------------------------
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            wr_state    <= W_IDLE;
            wr_ptr      <= '0;
            frame_start <= '0;
            len         <= '0;
            crc         <= '1;
            rx_err_seen <= 1'b0;
            ovf_seen    <= 1'b0;
            frame_good  <= 1'b0;
            frame_bad   <= 1'b0;
            drop_count  <= '0;
        end else begin
            frame_good <= 1'b0;
            frame_bad  <= 1'b0;

            case (wr_state)
                W_IDLE: begin
                    if (gmii_rx_dv && gmii_rxd == PRE_BYTE) begin
                        wr_state <= W_PRE;
                    end
                end

                W_PRE: begin
                    if (gmii_rx_dv && gmii_rxd == SFD_BYTE) begin
                        wr_state    <= W_BODY;
                        len         <= '0;
                        crc         <= '1;
                        rx_err_seen <= 1'b0;
                        ovf_seen    <= 1'b0;
                    end else if (!(gmii_rx_dv && gmii_rxd == PRE_BYTE)) begin
                        // Broken preamble: abandon silently.
                        wr_state <= W_IDLE;
                    end
                end

                W_BODY: begin
                    if (gmii_rx_er) begin
                        rx_err_seen <= 1'b1;
                    end
                    if (gmii_rx_dv) begin
                        crc <= crc32_step(crc, gmii_rxd);
                        if (len != LEN_SAT) begin
                            len <= len + 1'b1;
                        end
                        if (ram_we) begin
                            wr_ptr <= wr_ptr_inc;
                        end
                        // Once the ring fills, the frame is lost; keep writes
                        // off until dv falls even if the reader frees space.
                        if (len_below_max && buf_full_next) begin
                            ovf_seen <= 1'b1;
                        end
                    end else begin
                        wr_state <= W_CHECK;
                    end
                end

                W_CHECK: begin
                    if (frame_ok) begin
                        frame_start <= wr_ptr;
                        frame_good  <= 1'b1;
                    end else begin
                        wr_ptr    <= frame_start;
                        frame_bad <= 1'b1;
                        if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 1'b1;
                        end
                    end
                    // A new preamble may already be on the wire.
                    wr_state <= (gmii_rx_dv && gmii_rxd == PRE_BYTE) ? W_PRE : W_IDLE;
                end

                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Payload RAM: one write port (write FSM), one synchronous read port
    // -------------------------------------------------------------------------
    // NOTE: the RAM array and its read register are deliberately not reset;
    // pointers define which entries are meaningful, and a reset term would
    // stop the array mapping onto block RAM.
    always_ff @(posedge rx_clk) begin
        if (ram_we) begin
            mem[wr_ptr[ADDR_W-1:0]] <= gmii_rxd;
        end
        if (rd_fetch) begin
            ram_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    // -------------------------------------------------------------------------
    // Descriptor FIFO: {frame start, replay length} per committed frame
    // -------------------------------------------------------------------------
    always_ff @(posedge rx_clk) begin
        if (desc_push) begin
            desc_mem[desc_wr_idx] <= {frame_start, out_len};
        end
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            desc_wr_idx <= '0;
            desc_rd_idx <= '0;
            desc_count  <= '0;
        end else begin
            if (desc_push) begin
                desc_wr_idx <= desc_wr_idx + 1'b1;
            end
            if (desc_pop) begin
                desc_rd_idx <= desc_rd_idx + 1'b1;
            end
            case ({desc_push, desc_pop})
                2'b10:   desc_count <= desc_count + 1'b1;
                2'b01:   desc_count <= desc_count - 1'b1;
                default: desc_count <= desc_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read FSM and output pipeline
    //   pop edge -> RUN; each RUN cycle fetches one byte (RAM register), the
    //   next edge moves it into rx_data. First byte is visible two cycles
    //   after the pop.
    // -------------------------------------------------------------------------
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            rd_state    <= R_IDLE;
            rd_ptr      <= '0;
            rd_remain   <= '0;
            gap_cnt     <= '0;
            fetch_valid <= 1'b0;
            rx_enable   <= 1'b0;
            rx_data     <= '0;
        end else begin
            fetch_valid <= rd_fetch;
            rx_enable   <= fetch_valid;
            rx_data     <= fetch_valid ? ram_q : 8'h00;

            case (rd_state)
                R_IDLE: begin
                    if (desc_pop) begin
                        rd_ptr    <= desc_head.start;
                        rd_remain <= desc_head.len;
                        rd_state  <= R_RUN;
                    end
                end

                R_RUN: begin
                    rd_remain <= rd_remain - 1'b1;
                    if (rd_remain == LEN_W'(1)) begin
                        // Last fetch: step over any stripped FCS bytes so the
                        // pointer lands on the next frame's first byte.
                        rd_ptr   <= rd_ptr + RD_LAST_INC;
                        gap_cnt  <= GAP_LOAD;
                        rd_state <= R_GAP;
                    end else begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end

                R_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        rd_state <= R_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_checker
//
// Directed-stimulus bench with a scoreboard. The stimulus process builds
// frames (payload + FCS computed by a bit-serial reference CRC), pushes the
// expected verdict pulse, replay bytes and burst length into queues, then
// drives GMII. An independent monitor on the falling clock edge pops and
// compares whenever the DUT presents a pulse or a replayed byte.
// -----------------------------------------------------------------------------
module tb_rx_frame_checker;

    localparam int GAP_CYC = 2;
`ifdef RX_FCS_STRIP_EN
    localparam int STRIP = 4;
`else
    localparam int STRIP = 0;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic        rx_clk;
    logic        reset;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  rx_data;
    logic        rx_enable;
    logic        frame_good;
    logic        frame_bad;
    logic [15:0] drop_count;

    rx_frame_checker dut (
        .rx_clk     (rx_clk),
        .reset      (reset),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .rx_data    (rx_data),
        .rx_enable  (rx_enable),
        .frame_good (frame_good),
        .frame_bad  (frame_bad),
        .drop_count (drop_count)
    );

    initial rx_clk = 1'b0;
    always #4 rx_clk = ~rx_clk;

    // Scoreboard state
    logic [7:0]  exp_bytes[$];
    int          exp_lens[$];
    logic        exp_pulses[$];
    logic [11:0] exp_wr_ptr;
    logic [15:0] exp_drop;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference CRC-32, bit-serial, returns the final (complemented) value.
    function automatic logic [31:0] ref_crc(input byte_q_t data);
        logic [31:0] r;
        logic        fb;
        r = 32'hFFFFFFFF;
        foreach (data[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ data[i][b];
                r  = {1'b0, r[31:1]};
                if (fb) r = r ^ 32'hEDB88320;
            end
        end
        return ~r;
    endfunction

    function automatic byte_q_t make_frame(input int n_payload, input int seed);
        byte_q_t     q;
        logic [31:0] f;
        for (int i = 0; i < n_payload; i++) q.push_back(8'((i * 7 + seed) & 255));
        f = ref_crc(q);
        for (int k = 0; k < 4; k++) q.push_back(f[8*k +: 8]);
        return q;
    endfunction

    task automatic expect_good(input byte_q_t frm);
        int n;
        n = frm.size() - STRIP;
        exp_pulses.push_back(1'b1);
        for (int i = 0; i < n; i++) exp_bytes.push_back(frm[i]);
        exp_lens.push_back(n);
        exp_wr_ptr = exp_wr_ptr + 12'(frm.size());
    endtask

    task automatic expect_bad();
        exp_pulses.push_back(1'b0);
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(posedge rx_clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        gmii_rx_er = er;
    endtask

    task automatic send_frame(input byte_q_t frm, input int er_idx, input int ipg);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        foreach (frm[i]) drive(1'b1, frm[i], (i == er_idx));
        for (int i = 0; i < ipg; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_drain(input int budget);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge rx_clk);
            n++;
            done = (exp_bytes.size() == 0) && (exp_lens.size() == 0) &&
                   (exp_pulses.size() == 0) && !rx_enable;
        end
        check("drain_done", done, 1'b1);
        repeat (4) @(posedge rx_clk);
        #1;
    endtask

    // Monitor: compares everything the DUT presents against the queues.
    int   run_len    = 0;
    int   idle_len   = 0;
    logic seen_burst = 1'b0;

    always @(negedge rx_clk) begin : monitor
        logic p;
        if (reset) begin
            exp_bytes.delete();
            exp_lens.delete();
            exp_pulses.delete();
            run_len    = 0;
            idle_len   = 0;
            seen_burst = 1'b0;
        end else begin
            if (frame_good || frame_bad) begin
                check("pulse_exclusive", frame_good & frame_bad, 1'b0);
                check("pulse_expected", exp_pulses.size() != 0, 1'b1);
                if (exp_pulses.size() != 0) begin
                    p = exp_pulses.pop_front();
                    check("pulse_verdict", frame_good, p);
                end
            end
            if (rx_enable) begin
                if (run_len == 0 && seen_burst) check("gap_len_ok", idle_len >= GAP_CYC, 1'b1);
                check("byte_expected", exp_bytes.size() != 0, 1'b1);
                if (exp_bytes.size() != 0) check("replay_byte", rx_data, exp_bytes.pop_front());
                run_len++;
            end else begin
                check("idle_data_zero", rx_data, 8'h00);
                if (run_len != 0) begin
                    check("burst_expected", exp_lens.size() != 0, 1'b1);
                    if (exp_lens.size() != 0) check("burst_len", run_len, exp_lens.pop_front());
                    seen_burst = 1'b1;
                    idle_len   = 0;
                    run_len    = 0;
                end
                idle_len++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        byte_q_t frm;
        byte_q_t ref9;
        int      n;

        reset      = 1'b1;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        exp_wr_ptr = '0;
        exp_drop   = '0;

        repeat (3) @(posedge rx_clk);
        #1;
        check("rst_rx_enable",  rx_enable,  1'b0);
        check("rst_rx_data",    rx_data,    8'h00);
        check("rst_frame_good", frame_good, 1'b0);
        check("rst_frame_bad",  frame_bad,  1'b0);
        check("rst_drop_count", drop_count, 16'h0);
        check("rst_wr_ptr",     dut.wr_ptr, 12'h0);
        reset = 1'b0;

        // Anchor the reference CRC against the well-known check value.
        ref9 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("ref_crc_anchor", ref_crc(ref9), 32'hCBF43926);

        // 1) Good 64-byte frame.
        frm = make_frame(60, 1);
        expect_good(frm);
        send_frame(frm, -1, 12);
        check("t1_wr_ptr", dut.wr_ptr, exp_wr_ptr);
        wait_drain(500);
        check("t1_drop_count", drop_count, exp_drop);

        // 2) Same frame with one payload bit flipped.
        frm = make_frame(60, 1);
        frm[10] = frm[10] ^ 8'h04;
        expect_bad();
        send_frame(frm, -1, 12);
        check("t2_wr_ptr_rollback", dut.wr_ptr, exp_wr_ptr);
        wait_drain(500);
        check("t2_drop_count", drop_count, exp_drop);

        // 3) Good 1518-byte frame, then a 1519-byte frame.
        frm = make_frame(1514, 3);
        expect_good(frm);
        send_frame(frm, -1, 12);
        check("t3_wr_ptr_max", dut.wr_ptr, exp_wr_ptr);
        frm = make_frame(1515, 9);
        expect_bad();
        send_frame(frm, -1, 12);
        check("t3_wr_ptr_oversize", dut.wr_ptr, exp_wr_ptr);
        wait_drain(5000);
        check("t3_drop_count", drop_count, exp_drop);

        // 4) Eight back-to-back good 64-byte frames at 12-byte IPG.
        for (int k = 0; k < 8; k++) begin
            frm = make_frame(60, 13 * k + 20);
            expect_good(frm);
            send_frame(frm, -1, 12);
        end
        wait_drain(2000);
        check("t4_drop_count", drop_count, exp_drop);
        check("t4_wr_ptr", dut.wr_ptr, exp_wr_ptr);

        // 5) rx_er mid-frame with a valid FCS, then a broken preamble.
        frm = make_frame(60, 40);
        expect_bad();
        send_frame(frm, 30, 12);
        check("t5_wr_ptr_rollback", dut.wr_ptr, exp_wr_ptr);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b0);
        wait_drain(500);
        check("t5_drop_count", drop_count, exp_drop);

        // 6) Reset in the middle of a replay, then a clean frame.
        frm = make_frame(60, 77);
        expect_good(frm);
        send_frame(frm, -1, 4);
        n = 0;
        while (!rx_enable && n < 200) begin
            @(negedge rx_clk);
            n++;
        end
        check("t6_replay_started", rx_enable, 1'b1);
        repeat (5) @(posedge rx_clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_enable", rx_enable, 1'b0);
        check("t6_async_data",   rx_data,   8'h00);
        repeat (3) @(posedge rx_clk);
        #1;
        reset      = 1'b0;
        exp_wr_ptr = '0;
        exp_drop   = '0;
        check("t6_drop_cleared", drop_count, exp_drop);
        check("t6_wr_ptr_cleared", dut.wr_ptr, exp_wr_ptr);

        frm = make_frame(60, 99);
        expect_good(frm);
        send_frame(frm, -1, 12);
        check("t6_wr_ptr", dut.wr_ptr, exp_wr_ptr);
        wait_drain(500);
        check("t6_drop_count", drop_count, exp_drop);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
